// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared FSM state type and beat-counter sizing for burst_mem.
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // Width of the len field / remaining-beat counter; never below one bit.
    function automatic int unsigned len_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/burst_mem_if.sv
// burst_mem_if: request/beat bus between a requester (master) and burst_mem (slave).
interface burst_mem_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = 3
);
    logic                  valid;
    logic                  ready;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH/8-1:0]    wstrb;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  err;
    logic                  perr;

    modport master (
        output valid, wr_rd, addr, len, wdata, wstrb,
        input  ready, rdata, rvalid, rlast, err, perr
    );

    modport slave (
        input  valid, wr_rd, addr, len, wdata, wstrb,
        output ready, rdata, rvalid, rlast, err, perr
    );
endinterface

// File: rtl/burst_mem_parity.sv
// burst_mem_parity: even parity bit per byte (bit set when the byte has an odd number of ones).
module burst_mem_parity #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   data,
    output logic [WIDTH/8-1:0] par
);
    localparam int unsigned NBYTES = WIDTH / 8;

    // XOR-reduce each byte lane
    always_comb begin
        par = '0;
        for (int b = 0; b < NBYTES; b++) begin
            par[b] = ^data[b*8 +: 8];
        end
    end
endmodule

// File: rtl/burst_mem.sv
// burst_mem: single-port word memory with byte-strobed writes, wrapping
// incrementing bursts and a registered read path.
// Optional per-byte parity storage and checking: define BURST_MEM_PARITY_EN.
module burst_mem
    import burst_mem_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned MAX_BURST  = 8
) (
    input logic        clk,
    input logic        rst,
    burst_mem_if.slave bus
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned LEN_W  = len_width(MAX_BURST);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned AEXT_W = ADDR_WIDTH + 1;
    localparam logic [AEXT_W-1:0]     DEPTH_EXT = AEXT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Next burst address, wrapping from DEPTH-1 back to 0.
    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];

    logic                  xfer_c;
    logic                  addr_bad_c;
    logic                  mem_we_c;
    logic                  rd_en_c;
    logic                  rlast_c;
    logic [IDX_W-1:0]      widx_c;
    logic [IDX_W-1:0]      ridx_c;
    logic [WIDTH-1:0]      rd_word_c;

    // Requests are only taken outside READ; a pending reset blocks everything.
    assign bus.ready  = ~rst & (state_q != READ);
    assign xfer_c     = bus.valid & bus.ready;
    assign addr_bad_c = {1'b0, bus.addr} >= DEPTH_EXT;
    assign rd_word_c  = mem_q[ridx_c];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: single-beat requests never leave IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (xfer_c && !addr_bad_c && (bus.len != '0)) begin
                    state_d = bus.wr_rd ? WRITE : READ;
                end
            end
            WRITE: begin
                if (xfer_c && (cnt_q == LEN_W'(1))) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst control: address/counter update, write and read enables, error flag
    always_comb begin
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        mem_we_c = 1'b0;
        rd_en_c  = 1'b0;
        rlast_c  = 1'b0;
        err_d    = 1'b0;
        widx_c   = IDX_W'(addr_q);
        ridx_c   = IDX_W'(addr_q);
        unique case (state_q)
            IDLE: begin
                if (xfer_c && addr_bad_c) begin
                    err_d = 1'b1;
                end else if (xfer_c) begin
                    addr_d = wrap_inc(bus.addr);
                    cnt_d  = LEN_W'(bus.len);
                    if (bus.wr_rd) begin
                        mem_we_c = 1'b1;
                        widx_c   = IDX_W'(bus.addr);
                    end else begin
                        rd_en_c = 1'b1;
                        ridx_c  = IDX_W'(bus.addr);
                        rlast_c = (bus.len == '0);
                    end
                end
            end
            WRITE: begin
                if (xfer_c) begin
                    mem_we_c = 1'b1;
                    addr_d   = wrap_inc(addr_q);
                    cnt_d    = cnt_q - LEN_W'(1);
                end
            end
            READ: begin
                rd_en_c = 1'b1;
                rlast_c = (cnt_q == LEN_W'(1));
                addr_d  = wrap_inc(addr_q);
                cnt_d   = cnt_q - LEN_W'(1);
            end
            default: ;
        endcase
    end

    // Byte-strobed merge of the write beat into the addressed word
    always_comb begin
        mem_d = mem_q;
        if (mem_we_c) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.wstrb[b]) begin
                    mem_d[widx_c][b*8 +: 8] = bus.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read output: rdata holds its last value between beats
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        if (rd_en_c) begin
            rdata_d  = rd_word_c;
            rvalid_d = 1'b1;
            rlast_d  = rlast_c;
        end
    end

    // Burst bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            err_q    <= err_d;
        end
    end

    // Storage array; reset clears every word
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rlast  = rlast_q;
    assign bus.err    = err_q;

`ifdef BURST_MEM_PARITY_EN
    logic [NBYTES-1:0] par_q [DEPTH];
    logic [NBYTES-1:0] par_d [DEPTH];
    logic [NBYTES-1:0] wpar_c;
    logic [NBYTES-1:0] rpar_c;
    logic              perr_q, perr_d;

    burst_mem_parity #(.WIDTH(WIDTH)) u_wpar (
        .data (bus.wdata),
        .par  (wpar_c)
    );

    burst_mem_parity #(.WIDTH(WIDTH)) u_rpar (
        .data (rd_word_c),
        .par  (rpar_c)
    );

    // Parity bits follow the same byte strobes as the data
    always_comb begin
        par_d = par_q;
        if (mem_we_c) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.wstrb[b]) begin
                    par_d[widx_c][b] = wpar_c[b];
                end
            end
        end
    end

    // Recomputed parity of the word being read against the stored bits
    always_comb begin
        perr_d = rd_en_c && (rpar_c != par_q[ridx_c]);
    end

    // Parity storage and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= '{default: '0};
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem.sv
// tb_burst_mem: scoreboard bench for burst_mem (DEPTH=64, ADDR_WIDTH=7 so out-of-range addresses are reachable).
module tb_burst_mem;
    localparam int DEPTH = 64;
    localparam int AW    = 7;
    localparam int LW    = 3;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        perr;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_en;
    int   perr_addr;

    exp_t        sb[$];
    bit          err_at[int];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wbuf [8];
    logic [31:0] last_rdata;
    exp_t        mon_e;
    logic        mon_exp_v;

    burst_mem_if #(.WIDTH(32), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_if ();

    burst_mem #(
        .WIDTH      (32),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void ref_write(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    // Output monitor: every cycle, compare rvalid/err against expectations and pop read beats
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            check_eq("rvalid", bus_if.rvalid, mon_exp_v);
            check_eq("err", bus_if.err, err_at.exists(cyc));
            if (mon_exp_v) begin
                mon_e = sb.pop_front();
                check_eq("rdata", bus_if.rdata, mon_e.data);
                check_eq("rlast", bus_if.rlast, mon_e.last);
                check_eq("perr", bus_if.perr, mon_e.perr);
                last_rdata = mon_e.data;
            end else begin
                check_eq("rdata_hold", bus_if.rdata, last_rdata);
            end
        end
    end

    task automatic wait_ready();
        int i;
        i = 0;
        while (!bus_if.ready && i < 64) begin
            @(negedge clk);
            i++;
        end
        if (!bus_if.ready) check_eq("ready_wait", bus_if.ready, 1'b1);
    endtask

    task automatic do_read(input int a, input int l);
        int   n;
        exp_t e;
        wait_ready();
        n = cyc;
        bus_if.valid = 1'b1;
        bus_if.wr_rd = 1'b0;
        bus_if.addr  = AW'(a);
        bus_if.len   = LW'(l);
        bus_if.wdata = $urandom;
        bus_if.wstrb = 4'($urandom);
        if (a < DEPTH) begin
            for (int k = 0; k <= l; k++) begin
                e.data = ref_mem[(a + k) % DEPTH];
                e.last = (k == l);
                e.perr = (((a + k) % DEPTH) == perr_addr);
                e.cyc  = n + 1 + k;
                sb.push_back(e);
            end
        end else begin
            err_at[n + 1] = 1'b1;
        end
        @(negedge clk);
        bus_if.valid = 1'b0;
    endtask

    task automatic do_write(input int a, input int l, input logic [3:0] strb, input int gap);
        int n;
        int g;
        wait_ready();
        n = cyc;
        bus_if.valid = 1'b1;
        bus_if.wr_rd = 1'b1;
        bus_if.addr  = AW'(a);
        bus_if.len   = LW'(l);
        bus_if.wdata = wbuf[0];
        bus_if.wstrb = strb;
        if (a < DEPTH) ref_write(a, wbuf[0], strb);
        else err_at[n + 1] = 1'b1;
        @(negedge clk);
        if (a < DEPTH) begin
            for (int k = 1; k <= l; k++) begin
                g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
                repeat (g) begin
                    bus_if.valid = 1'b0;
                    bus_if.wdata = $urandom;
                    bus_if.wstrb = 4'hF;
                    @(negedge clk);
                end
                bus_if.valid = 1'b1;
                bus_if.wr_rd = 1'($urandom);
                bus_if.addr  = AW'($urandom);
                bus_if.len   = LW'($urandom);
                bus_if.wdata = wbuf[k];
                bus_if.wstrb = strb;
                check_eq("wr_beat_ready", bus_if.ready, 1'b1);
                ref_write((a + k) % DEPTH, wbuf[k], strb);
                @(negedge clk);
            end
        end
        bus_if.valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"},  bus_if.ready,  1'b0);
        check_eq({pfx, "_rvalid"}, bus_if.rvalid, 1'b0);
        check_eq({pfx, "_rlast"},  bus_if.rlast,  1'b0);
        check_eq({pfx, "_rdata"},  bus_if.rdata,  32'h0);
        check_eq({pfx, "_err"},    bus_if.err,    1'b0);
        check_eq({pfx, "_perr"},   bus_if.perr,   1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst          = 1'b1;
        mon_en       = 1'b0;
        perr_addr    = -1;
        last_rdata   = '0;
        bus_if.valid = 1'b0;
        bus_if.wr_rd = 1'b0;
        bus_if.addr  = '0;
        bus_if.len   = '0;
        bus_if.wdata = '0;
        bus_if.wstrb = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", bus_if.ready, 1'b1);
        mon_en = 1'b1;

        // Single write then single read
        wbuf[0] = 32'hDEADBEEF;
        do_write(5, 0, 4'hF, 0);
        do_read(5, 0);

        // Byte strobes
        wbuf[0] = 32'h11223344;
        do_write(2, 0, 4'hF, 0);
        wbuf[0] = 32'hAABBCCDD;
        do_write(2, 0, 4'h5, 0);
        do_read(2, 0);

        // Back-to-back single reads, one per cycle
        t0 = cyc;
        for (int i = 0; i < 16; i++) do_read(i, 0);
        check_eq("b2b_cycles", 64'(cyc - t0), 64'd16);

        // Wrapping burst write/read, ready low during read burst
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(62, 3, 4'hF, 0);
        do_read(62, 3);
        check_eq("burst_ready_1", bus_if.ready, 1'b0);
        @(negedge clk);
        check_eq("burst_ready_2", bus_if.ready, 1'b0);
        @(negedge clk);
        check_eq("burst_ready_3", bus_if.ready, 1'b0);
        @(negedge clk);
        check_eq("burst_ready_end", bus_if.ready, 1'b1);
        do_read(0, 0);

        // Out-of-range requests: read, single write, burst write
        do_read(70, 0);
        wbuf[0] = 32'hBAD0BAD0;
        do_write(70, 0, 4'hF, 0);
        do_write(70, 3, 4'hF, 0);
        check_eq("err_stays_idle", bus_if.ready, 1'b1);
        do_read(6, 0);

        // Stalled write burst
        for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
        do_write(20, 7, 4'hF, 3);
        do_read(20, 7);

        // Random mix
        for (int it = 0; it < 40; it++) begin
            int a;
            int l;
            int g;
            logic [3:0] s;
            a = ($urandom_range(7, 0) == 0) ? int'($urandom_range(127, 64)) : int'($urandom_range(63, 0));
            l = $urandom_range(7, 0);
            s = 4'($urandom);
            g = $urandom_range(2, 0);
            for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
            if ($urandom_range(1, 0) == 1) do_write(a, l, s, g);
            else do_read(a, l);
        end

        // Full memory sweep against the model
        for (int a = 0; a < DEPTH; a += 8) do_read(a, 7);

        // Parity: corrupt a stored bit when parity is built in
`ifdef BURST_MEM_PARITY_EN
        dut.mem_q[3] = dut.mem_q[3] ^ 32'h1;
        ref_mem[3]   = ref_mem[3] ^ 32'h1;
        perr_addr    = 3;
`endif
        do_read(3, 0);
        do_read(4, 0);

        // Reset in the middle of a len=7 read burst
        do_read(0, 7);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("ready_after_abort", bus_if.ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_rdata = '0;
        err_at.delete();
        perr_addr  = -1;
        mon_en     = 1'b1;
        for (int a = 0; a < DEPTH; a += 8) do_read(a, 7);

        repeat (10) @(negedge clk);
        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/burst_mem.md
BURST_MEM -- requirements
Module: burst_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; any value >= 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter MAX_BURST, default 8, maximum beats per burst; a power of two.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 valid  input  1  request/beat valid.
REQ-008 ready  output  1  block can accept a request or beat.
REQ-009 wr_rd  input  1  1 = write, 0 = read; sampled at request acceptance only.
REQ-010 addr  input  ADDR_WIDTH  start address; sampled at acceptance only.
REQ-011 len  input  $clog2(MAX_BURST)  beats minus one; sampled at acceptance only.
REQ-012 wdata  input  WIDTH  write data per beat.
REQ-013 wstrb  input  WIDTH/8  byte write enables per beat.
REQ-014 rdata  output  WIDTH  read data, registered.
REQ-015 rvalid  output  1  rdata valid this cycle.
REQ-016 rlast  output  1  last read beat of the burst.
REQ-017 err  output  1  one-cycle pulse when a request is rejected.
REQ-018 perr  output  1  parity error on the current read beat.

Function
REQ-019 A transfer SHALL occur only on a cycle with valid && ready.
REQ-020 The FSM SHALL have three states: IDLE, WRITE, READ.
REQ-021 ready SHALL be 1 in IDLE and WRITE, and 0 in READ.
REQ-022 In IDLE, a transfer with addr >= DEPTH SHALL be dropped, pulse err the next cycle, and leave the state at IDLE.
REQ-023 In IDLE, an accepted write SHALL write beat 0 on that cycle; if len > 0, go to WRITE with len remaining beats.
REQ-024 In WRITE, each transfer SHALL write the next address; wr_rd, addr and len SHALL be ignored; return to IDLE after the last beat.
REQ-025 A write SHALL update only the bytes whose wstrb bit is 1; other bytes SHALL be preserved.
REQ-026 An accepted read at cycle T SHALL read beat k at cycle T+k and present it with rvalid=1 at cycle T+1+k, k = 0..len.
REQ-027 For a read with len > 0, the FSM SHALL be in READ for cycles T+1..T+len and in IDLE at T+len+1.
REQ-028 For a read with len = 0, the FSM SHALL stay in IDLE, so back-to-back single reads sustain one per cycle.
REQ-029 rlast SHALL be 1 exactly with the beat k = len.
REQ-030 rdata SHALL hold its last value when rvalid = 0.
REQ-031 Burst addresses SHALL wrap from DEPTH-1 to 0.
REQ-032 Within a write burst, valid = 0 cycles SHALL stall without timeout.

Reset
REQ-033 While rst = 1, the block SHALL force state IDLE and clear all memory words to 0.
REQ-034 While rst = 1: ready = 0, rdata = 0, rvalid = 0, rlast = 0, err = 0, perr = 0.
REQ-035 ready SHALL be 1 on the first cycle after rst deasserts.
REQ-036 Reset during a burst SHALL abort the burst; no further beats SHALL be written or returned.

Configuration
REQ-037 With macro BURST_MEM_PARITY_EN defined, the block SHALL store one even-parity bit per byte, updated on byte write.
REQ-038 With BURST_MEM_PARITY_EN defined, perr SHALL be 1 with any rvalid beat whose recomputed parity mismatches the stored parity.
REQ-039 Without BURST_MEM_PARITY_EN, the block SHALL store no parity, and perr SHALL be tied to 0.

Structure
REQ-040 Package burst_mem_pkg SHALL hold the FSM state typedef (IDLE/WRITE/READ) and the beat-count width function or constant.
REQ-041 Per-byte parity generation SHALL be a sub-module named burst_mem_parity, instantiated only under BURST_MEM_PARITY_EN.

Verification
REQ-042 Single read/write: write 0xDEADBEEF to addr 5 (wstrb=0xF, len=0), then read addr 5 -> rdata=0xDEADBEEF, rvalid=1, rlast=1 one cycle after acceptance.
REQ-043 Byte strobes: write 0x11223344 to addr 2, then 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
REQ-044 Wrapping burst: with DEPTH=64, write len=3 at addr 62 with data 1,2,3,4 -> addrs 62,63,0,1 hold 1,2,3,4; read burst returns 1,2,3,4 on consecutive cycles; ready=0 for 3 cycles; rlast on beat 4.
REQ-045 Error: request with addr=70 under DEPTH=64 (ADDR_WIDTH=7) -> err pulse one cycle later; no memory change; no rvalid.
REQ-046 Reset mid-burst: assert rst during beat 2 of a len=7 read -> rvalid=0 the next cycle, ready=1 after rst release, all words read back 0.
REQ-047 Parity (macro on): force a stored data bit flipped at addr 3, then read addr 3 -> perr=1 with rvalid; macro off -> perr=0.
